cacheline_burst_adapter: RTL and testbench

//  Responder on the cache's physical-memory port (pmem_read/pmem_write/pmem_resp, 256-bit line).

---
 rtl/cacheline_burst_adapter.sv | 143 ++++++++++++++
 tb/tb_cacheline_burst_adapter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_burst_adapter.sv
// Cache-line to DRAM burst adapter.
//
// Accepts one whole-line read or write from the cache's physical-memory port.
// Each request becomes a fixed-length burst of narrow beats on the DRAM side.
// One line-level response is returned when the burst is complete.
//
// Ports:
//   clk_i, rst_ni      clock; asynchronous active-low reset
//   line_address_i     cache line address (offset bits ignored)
//   line_wdata_i       full line to write
//   line_read_i        cache read request, held until line_resp_o
//   line_write_i       cache write request, held until line_resp_o
//   line_rdata_o       assembled read line, valid while line_resp_o is high
//   line_resp_o        one-cycle completion pulse
//   burst_address_o    line-aligned DRAM address
//   burst_wdata_o      current write beat
//   burst_rdata_i      current read beat
//   burst_read_o       DRAM read request, held for the whole burst
//   burst_write_o      DRAM write request, held for the whole burst
//   burst_resp_i       DRAM beat strobe, one per transferred beat
module cacheline_burst_adapter #(
    parameter int unsigned LineW  = 256,
    parameter int unsigned BurstW = 64,
    parameter int unsigned AddrW  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [AddrW-1:0]  line_address_i,
    input  logic [LineW-1:0]  line_wdata_i,
    input  logic              line_read_i,
    input  logic              line_write_i,
    output logic [LineW-1:0]  line_rdata_o,
    output logic              line_resp_o,
    output logic [AddrW-1:0]  burst_address_o,
    output logic [BurstW-1:0] burst_wdata_o,
    input  logic [BurstW-1:0] burst_rdata_i,
    output logic              burst_read_o,
    output logic              burst_write_o,
    input  logic              burst_resp_i
);

    localparam int unsigned Beats  = LineW / BurstW;
    localparam int unsigned Offset = $clog2(LineW / 8);
    localparam int unsigned CntW   = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [AddrW-1:0] OffMask = AddrW'((64'd1 << Offset) - 64'd1);
    localparam logic [CntW-1:0]  LastBeat = CntW'(Beats - 1);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [AddrW-1:0]  addr_q, addr_d;
    logic [LineW-1:0]  wdata_q, wdata_d;
    logic [LineW-1:0]  rdata_q, rdata_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                // Read has priority when both requests are raised together.
                if (line_read_i) begin
                    addr_d  = line_address_i & ~OffMask;
                    count_d = '0;
                    state_d = StRd;
                end else if (line_write_i) begin
                    addr_d  = line_address_i & ~OffMask;
                    wdata_d = line_wdata_i;
                    count_d = '0;
                    state_d = StWr;
                end
            end
            StRd: begin
                if (burst_resp_i) begin
                    rdata_d[count_q*BurstW +: BurstW] = burst_rdata_i;
                    // Count stays at the last beat; it is cleared on the next accept.
                    if (count_q == LastBeat) begin
                        state_d = StDone;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            StWr: begin
                if (burst_resp_i) begin
                    if (count_q == LastBeat) begin
                        state_d = StDone;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            StDone: begin
                // Requests still held by the cache here are ignored.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        line_resp_o     = 1'b0;
        burst_read_o    = 1'b0;
        burst_write_o   = 1'b0;
        burst_address_o = '0;
        burst_wdata_o   = '0;
        unique case (state_q)
            StRd: begin
                burst_read_o    = 1'b1;
                burst_address_o = addr_q;
            end
            StWr: begin
                burst_write_o   = 1'b1;
                burst_address_o = addr_q;
                burst_wdata_o   = wdata_q[count_q*BurstW +: BurstW];
            end
            StDone: line_resp_o = 1'b1;
            default: ;
        endcase
    end

    assign line_rdata_o = rdata_q;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
module tb_cacheline_burst_adapter;

    logic         clk;
    logic         rst_n;
    logic [31:0]  line_address;
    logic [255:0] line_wdata;
    logic         line_read;
    logic         line_write;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic [31:0]  burst_address;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_read;
    logic         burst_write;
    logic         burst_resp;

    cacheline_burst_adapter dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .line_address_i (line_address),
        .line_wdata_i   (line_wdata),
        .line_read_i    (line_read),
        .line_write_i   (line_write),
        .line_rdata_o   (line_rdata),
        .line_resp_o    (line_resp),
        .burst_address_o(burst_address),
        .burst_wdata_o  (burst_wdata),
        .burst_rdata_i  (burst_rdata),
        .burst_read_o   (burst_read),
        .burst_write_o  (burst_write),
        .burst_resp_i   (burst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           is_read;
        logic [255:0] data;
    } exp_t;

    exp_t         sb_q[$];
    logic [255:0] mem [logic [31:0]];
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cache request; this task also plays the DRAM, gapping beats by `gap` idle cycles.
    // abort_at > 0 pulses reset once that many beats have been transferred.
    // hold keeps the request asserted past line_resp.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [255:0] wdata, input logic [255:0] exp_rd,
                          input int gap, input int abort_at, input bit hold);
        int           beat = 0;
        int           gcnt = 0;
        int           cyc = 0;
        int           last_beat_cyc = -10;
        bit           done = 0;
        bit           aborted = 0;
        bit           is_rd = rd;
        logic [31:0]  line_a = addr & 32'hffff_ffe0;
        logic [255:0] m;
        exp_t         e;
        e.is_read = rd;
        e.data    = rd ? exp_rd : wdata;
        sb_q.push_back(e);
        line_read    = rd;
        line_write   = wr;
        line_address = addr;
        line_wdata   = wdata;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            burst_resp = 1'b0;
            check_eq("rd_wr_exclusive", 256'(burst_read & burst_write), 256'(0));
            if (line_resp) begin
                check_eq("resp_latency", 256'(cyc), 256'(last_beat_cyc + 1));
                check_eq("beats_before_resp", 256'(beat), 256'(4));
                if (sb_q.size() == 0) begin
                    check_eq("sb_nonempty", 256'(0), 256'(1));
                end else begin
                    e = sb_q.pop_front();
                    if (e.is_read) check_eq("line_rdata", line_rdata, e.data);
                end
                if (!hold) begin
                    line_read  = 1'b0;
                    line_write = 1'b0;
                end
                done = 1;
            end else if (burst_read || burst_write) begin
                check_eq("burst_address", 256'(burst_address), 256'(line_a));
                check_eq("burst_read_dir", 256'(burst_read), 256'(is_rd));
                check_eq("burst_write_dir", 256'(burst_write), 256'(!is_rd));
                if (abort_at > 0 && beat == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    check_eq("rst_line_resp", 256'(line_resp), 256'(0));
                    check_eq("rst_burst_read", 256'(burst_read), 256'(0));
                    check_eq("rst_burst_write", 256'(burst_write), 256'(0));
                    check_eq("rst_burst_address", 256'(burst_address), 256'(0));
                    check_eq("rst_burst_wdata", 256'(burst_wdata), 256'(0));
                    check_eq("rst_line_rdata", line_rdata, 256'(0));
                    line_read  = 1'b0;
                    line_write = 1'b0;
                    @(negedge clk);
                    check_eq("rst_hold_resp", 256'(line_resp), 256'(0));
                    rst_n = 1'b1;
                    void'(sb_q.pop_front());
                    aborted = 1;
                    done = 1;
                end else begin
                    if (!is_rd) check_eq("burst_wdata_lane", 256'(burst_wdata), 256'(wdata[beat*64 +: 64]));
                    if (gcnt == gap) begin
                        burst_resp = 1'b1;
                        m = mem.exists(line_a) ? mem[line_a] : '0;
                        if (is_rd) begin
                            burst_rdata = m[beat*64 +: 64];
                        end else begin
                            m[beat*64 +: 64] = burst_wdata;
                            mem[line_a] = m;
                        end
                        beat++;
                        last_beat_cyc = cyc;
                        gcnt = 0;
                    end else begin
                        gcnt++;
                    end
                end
            end
        end
        if (!done) begin
            check_eq("resp_timeout", 256'(0), 256'(1));
            line_read  = 1'b0;
            line_write = 1'b0;
            burst_resp = 1'b0;
        end else if (!aborted) begin
            @(negedge clk);
            check_eq("resp_single_pulse", 256'(line_resp), 256'(0));
            check_eq("idle_after_done", 256'(burst_read | burst_write), 256'(0));
        end
    endtask

    localparam logic [255:0] Line1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] WLine = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                      64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    localparam logic [255:0] Fresh = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                      64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_3C3C_C3C3};
    localparam logic [255:0] Line6 = {64'hCAFE_0004_CAFE_0004, 64'hCAFE_0003_CAFE_0003,
                                      64'hCAFE_0002_CAFE_0002, 64'hCAFE_0001_CAFE_0001};

    initial begin
        rst_n        = 1'b0;
        line_address = '0;
        line_wdata   = '0;
        line_read    = 1'b0;
        line_write   = 1'b0;
        burst_rdata  = '0;
        burst_resp   = 1'b0;
        mem[32'h0000_1220] = Line1;
        mem[32'h0000_4000] = Fresh;
        mem[32'h0000_2040] = 256'h1;
        repeat (2) @(negedge clk);
        check_eq("reset_line_resp", 256'(line_resp), 256'(0));
        check_eq("reset_burst_rw", 256'({burst_read, burst_write}), 256'(0));
        check_eq("reset_burst_address", 256'(burst_address), 256'(0));
        check_eq("reset_burst_wdata", 256'(burst_wdata), 256'(0));
        check_eq("reset_line_rdata", line_rdata, 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: read, back-to-back beats, unaligned address
        do_req(1, 0, 32'h0000_1234, '0, Line1, 0, 0, 0);
        // line_rdata holds after the response
        check_eq("rdata_holds", line_rdata, Line1);
        // 2: write, one beat every third cycle
        do_req(0, 1, 32'h0000_3000, WLine, '0, 2, 0, 0);
        // 3: read and write together, read wins
        do_req(1, 1, 32'h0000_1220, WLine, Line1, 0, 0, 0);
        // 4: reset after two beats of a read, then a normal read
        do_req(1, 0, 32'h0000_2040, '0, 256'h1, 0, 2, 0);
        do_req(1, 0, 32'h0000_4010, '0, Fresh, 1, 0, 0);
        // 5: stray strobes in IDLE, then read held through DONE
        burst_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stray_no_resp", 256'(line_resp), 256'(0));
            check_eq("stray_no_burst", 256'(burst_read | burst_write), 256'(0));
        end
        burst_resp = 1'b0;
        do_req(1, 0, 32'h0000_1220, '0, Line1, 0, 0, 1);
        do_req(1, 0, 32'h0000_1220, '0, Line1, 0, 0, 0);
        // 6: write then read back the same line
        do_req(0, 1, 32'h0000_5020, Line6, '0, 0, 0, 0);
        do_req(1, 0, 32'h0000_503F, '0, Line6, 1, 0, 0);

        check_eq("scoreboard_drained", 256'(sb_q.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
